// File: rtl/arb_pkg.sv
// Shared types and defaults for the CPU / character-scan data RAM arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        WAITREL = 2'd2
    } arb_state_t;

    // One-hot so each bit can drive its own datapath select directly.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_CPU  = 2'b01,
        GRANT_IO   = 2'b10
    } grant_t;

    localparam logic [11:0] DEF_CHARBASE  = 12'h400;
    localparam int          DEF_CHARCOUNT = 100;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter between the CPU data port and the I/O scan engine.
// ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin.
module rr_arbiter2
    import arb_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   cpu_req,
    input  logic   io_req,
    output grant_t grant
);

`ifdef ARB_CPU_PRIORITY_EN
    wire unused_clk = clock ^ reset;

    always_comb begin
        grant = GRANT_NONE;
        if (cpu_req)     grant = GRANT_CPU;
        else if (io_req) grant = GRANT_IO;
    end
`else
    logic lastGrant;  // 1: I/O won the most recent contested cycle

    always_comb begin
        grant = GRANT_NONE;
        if (cpu_req && io_req) grant = lastGrant ? GRANT_CPU : GRANT_IO;
        else if (cpu_req)      grant = GRANT_CPU;
        else if (io_req)       grant = GRANT_IO;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 lastGrant <= 1'b0;
        else if (cpu_req && io_req) lastGrant <= (grant == GRANT_IO);
    end
`endif

endmodule

// File: rtl/io_mem_arbiter.sv
// Shares the data RAM between the MEM-stage port and the character-scan engine.
// Optional macro ARB_CPU_PRIORITY_EN: CPU always wins, cpuStall tied low.
module io_mem_arbiter
    import arb_pkg::*;
#(
    parameter int                      WIDTH        = 36,
    parameter int                      MEMADDRWIDTH = 12,
    parameter logic [MEMADDRWIDTH-1:0] CHARBASE     = MEMADDRWIDTH'(DEF_CHARBASE),
    parameter int                      CHARCOUNT    = DEF_CHARCOUNT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpuReq,
    input  logic                    cpuWe,
    input  logic [WIDTH-1:0]        cpuAddr,
    input  logic [WIDTH-1:0]        cpuWdata,
    output logic [WIDTH-1:0]        cpuRdata,
    output logic                    cpuStall,
    input  logic                    startIO,
    output logic                    ioBusy,
    output logic                    ioDone,
    output logic                    ioCharValid,
    output logic [7:0]              ioChar,
    output logic [6:0]              ioCharIdx,
    output logic [MEMADDRWIDTH-1:0] memAddr,
    output logic                    memWe,
    output logic [WIDTH-1:0]        memWdata,
    input  logic [WIDTH-1:0]        memRdata
);

    localparam logic [6:0] COUNT    = 7'(CHARCOUNT);
    localparam logic [6:0] LAST_IDX = 7'(CHARCOUNT - 1);

    arb_state_t              state;
    logic [6:0]              issueCnt, retCnt;
    logic                    ioRdPend, cpuRdPend;
    logic [WIDTH-1:0]        rdata_q, wdata_q;
    logic [MEMADDRWIDTH-1:0] addr_q;
    logic                    io_req, grant_cpu, grant_io;
    grant_t                  grant;

    wire unused_addr = ^cpuAddr[WIDTH-1:MEMADDRWIDTH];

    assign io_req = (state == SCAN) && (issueCnt < COUNT);

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .cpu_req (cpuReq),
        .io_req  (io_req),
        .grant   (grant)
    );

    assign grant_cpu = (grant == GRANT_CPU);
    assign grant_io  = (grant == GRANT_IO);

`ifdef ARB_CPU_PRIORITY_EN
    assign cpuStall = 1'b0;
`else
    assign cpuStall = cpuReq & ~grant_cpu;
`endif

    // The RAM samples its address in the grant cycle, so the port is driven
    // combinationally; the _q copies give the hold-last-value behaviour.
    always_comb begin
        memAddr  = addr_q;
        memWe    = 1'b0;
        memWdata = wdata_q;
        if (grant_cpu) begin
            memAddr  = cpuAddr[MEMADDRWIDTH-1:0];
            memWe    = cpuWe;
            memWdata = cpuWdata;
        end else if (grant_io) begin
            memAddr = CHARBASE + MEMADDRWIDTH'(issueCnt);
        end
    end

    assign cpuRdata    = cpuRdPend ? memRdata : rdata_q;
    assign ioCharValid = ioRdPend;
    assign ioChar      = ioRdPend ? memRdata[7:0] : 8'h00;
    assign ioCharIdx   = ioRdPend ? retCnt : 7'd0;
    assign ioDone      = ioRdPend && (retCnt == LAST_IDX);
    assign ioBusy      = (state == SCAN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            issueCnt  <= '0;
            retCnt    <= '0;
            ioRdPend  <= 1'b0;
            cpuRdPend <= 1'b0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
        end else begin
            addr_q    <= memAddr;
            wdata_q   <= memWdata;
            rdata_q   <= cpuRdata;
            ioRdPend  <= grant_io;
            cpuRdPend <= grant_cpu & ~cpuWe;
            if (grant_io) issueCnt <= issueCnt + 7'd1;
            if (ioRdPend) retCnt   <= retCnt + 7'd1;
            case (state)
                IDLE: begin
                    issueCnt <= '0;
                    retCnt   <= '0;
                    if (startIO) state <= SCAN;
                end
                SCAN:    if (ioDone)   state <= WAITREL;
                WAITREL: if (!startIO) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
